// File: rtl/bcd_display_scheduler_pkg.sv
// rtl/bcd_display_scheduler_pkg.sv - shared FSM encodings, digit indices and BCD field helpers
package bcd_display_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    STORE = 2'd2
  } conv_state_t;

  localparam logic [1:0] DIG_UNITS    = 2'd0;
  localparam logic [1:0] DIG_TENS     = 2'd1;
  localparam logic [1:0] DIG_HUNDREDS = 2'd2;

  localparam int UNITS_LSB    = 0;
  localparam int TENS_LSB     = 4;
  localparam int HUNDREDS_LSB = 8;

  // Hundreds field is only two bits wide; it is zero-extended to a full nibble.
  function automatic logic [3:0] bcd_digit(input logic [9:0] bcd, input logic [1:0] dig);
    case (dig)
      DIG_TENS:     return bcd[TENS_LSB +: 4];
      DIG_HUNDREDS: return {2'b00, bcd[HUNDREDS_LSB +: 2]};
      default:      return bcd[UNITS_LSB +: 4];
    endcase
  endfunction

endpackage

// File: rtl/bcd_display_scheduler_if.sv
// rtl/bcd_display_scheduler_if.sv - requester handshake bundle (req / req_val / ack)
interface bcd_display_scheduler_if #(
  parameter int N_REQ = 3
) ();

  logic [N_REQ-1:0]   req;
  logic [8*N_REQ-1:0] req_val;
  logic [N_REQ-1:0]   ack;

  modport master (output req, output req_val, input ack);
  modport slave  (input req, input req_val, output ack);

endinterface

// File: rtl/bcd_display_scheduler_rr_arbiter.sv
// rtl/bcd_display_scheduler_rr_arbiter.sv - round-robin arbiter, first request at or after ptr wins
module rr_arbiter #(
  parameter int N_REQ = 3
) (
  input  logic [N_REQ-1:0] req,
  input  logic [1:0]       ptr,
  output logic [N_REQ-1:0] grant,
  output logic [1:0]       grant_idx
);

  logic [3:0] req4;
  logic [1:0] cand;
  logic       found;

  always_comb begin
    req4      = 4'(req);
    grant     = '0;
    grant_idx = '0;
    cand      = '0;
    found     = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = 2'((int'(ptr) + k) % N_REQ);
      if (!found && req4[cand]) begin
        found     = 1'b1;
        grant_idx = cand;
        for (int j = 0; j < N_REQ; j++) begin
          if (2'(j) == cand) grant[j] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/bcd_display_scheduler.sv
// rtl/bcd_display_scheduler.sv - shared BCD converter scheduler with 3-digit scanned display
// Optional build macro: LEADING_ZERO_BLANK_EN (blanks leading zero hundreds/tens digits).
module bcd_display_scheduler
  import bcd_display_scheduler_pkg::*;
#(
  parameter int N_REQ    = 3,
  parameter int CONV_LAT = 1,
  parameter int SCAN_DIV = 50000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  bcd_display_scheduler_if.slave       req_bus,
  output logic [7:0]                   conv_bin,
  input  logic [9:0]                   conv_bcd,
  input  logic [1:0]                   disp_sel,
  output logic [2:0]                   dig_en,
  output logic [3:0]                   dig_bcd,
  output logic                         blank,
  output logic                         busy
);

  localparam int SCAN_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  conv_state_t      state, state_nxt;
  logic [1:0]       idx, ptr;
  logic [2:0]       wait_cnt;
  logic [N_REQ-1:0] grant;
  logic [1:0]       grant_idx;
  logic [7:0]       grant_val;
  logic [9:0]       slot [4];
  logic [3:0]       valid;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req       (req_bus.req),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_comb begin
    grant_val = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) grant_val = req_bus.req_val[8*i +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    req_bus.ack = '0;
    case (state)
      IDLE:    if (|req_bus.req) state_nxt = ISSUE;
      ISSUE:   if (wait_cnt == 3'(CONV_LAT - 1)) state_nxt = STORE;
      STORE: begin
        state_nxt   = IDLE;
        req_bus.ack = N_REQ'(1) << idx;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // conv_bin doubles as the latched operand, so it naturally holds in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx      <= '0;
      ptr      <= '0;
      wait_cnt <= '0;
      conv_bin <= '0;
      valid    <= '0;
      for (int i = 0; i < 4; i++) slot[i] <= '0;
    end else begin
      case (state)
        IDLE: if (|req_bus.req) begin
          idx      <= grant_idx;
          conv_bin <= grant_val;
          wait_cnt <= '0;
        end
        ISSUE: wait_cnt <= wait_cnt + 3'd1;
        STORE: begin
          slot[idx]  <= conv_bcd;
          valid[idx] <= 1'b1;
          ptr        <= (idx == 2'(N_REQ - 1)) ? 2'd0 : idx + 2'd1;
        end
        default: ;
      endcase
    end
  end

  logic [SCAN_W-1:0] scan_cnt;
  logic [1:0]        dig_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      dig_idx  <= DIG_UNITS;
    end else if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
      scan_cnt <= '0;
      dig_idx  <= (dig_idx == DIG_HUNDREDS) ? DIG_UNITS : dig_idx + 2'd1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  logic [9:0] sel_bcd;
  logic       blank_nxt;
  logic [3:0] nib_nxt;

  always_comb begin
    sel_bcd   = slot[disp_sel];
    blank_nxt = !((int'(disp_sel) < N_REQ) && valid[disp_sel]);
`ifdef LEADING_ZERO_BLANK_EN
    if (dig_idx == DIG_HUNDREDS && sel_bcd[HUNDREDS_LSB +: 2] == 2'd0)
      blank_nxt = 1'b1;
    if (dig_idx == DIG_TENS && sel_bcd[HUNDREDS_LSB +: 2] == 2'd0 && sel_bcd[TENS_LSB +: 4] == 4'd0)
      blank_nxt = 1'b1;
`endif
    nib_nxt = blank_nxt ? 4'd0 : bcd_digit(sel_bcd, dig_idx);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dig_en  <= 3'b001;
      dig_bcd <= '0;
      blank   <= 1'b1;
    end else begin
      dig_en  <= 3'b001 << dig_idx;
      dig_bcd <= nib_nxt;
      blank   <= blank_nxt;
    end
  end

endmodule
